// File: rtl/countdown_timer_pkg.sv
// Shared widths, FSM encodings and digit payload for the countdown timer.
package countdown_timer_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [BCD_W-1:0] BCD_MAX = BCD_W'(9);

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } mmss_t;

  function automatic logic mmss_is_zero(input mmss_t t);
    return (t == '0);
  endfunction

  // True when the next decrement lands on 00:00.
  function automatic logic mmss_is_last_second(input mmss_t t);
    return (t.min_tens == '0) && (t.min_ones == '0) &&
           (t.sec_tens == '0) && (t.sec_ones == BCD_W'(1));
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the MM:SS register: parallel load for key shifts, decrement with borrow.
module countdown_timer_bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] WRAP = BCD_MAX
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= (q == '0) ? WRAP : q - BCD_W'(1);
    end
  end

  // Borrow ripples to the next digit in the same cycle.
  assign borrow_out = dec && (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer fed by the keypad encoder; counts down on synchronised 1 Hz ticks.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SEC_TENS_WRAP = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [BCD_W-1:0] D,
  input  logic             loadn,
  input  logic             pgt_1Hz,
  input  logic             enablen,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             zero,
  output logic             done
);

  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   load_prev;
  logic                   tick_prev;
  logic                   load_evt_c;
  logic                   tick_evt_c;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic               done_d;
  logic               dec_c;
  logic               load_c;

  logic  so_borrow;
  logic  st_borrow;
  logic  mo_borrow;
  logic  mt_borrow_unused;
  mmss_t digits;

  // Synchronisers reset to the inactive level so reset release never fakes an event.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      load_sync <= '1;
      load_prev <= 1'b1;
      tick_sync <= '0;
      tick_prev <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], loadn};
      load_prev <= load_sync[SYNC_STAGES-1];
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], pgt_1Hz};
      tick_prev <= tick_sync[SYNC_STAGES-1];
    end
  end

  assign load_evt_c = load_prev && !load_sync[SYNC_STAGES-1];
  assign tick_evt_c = !tick_prev && tick_sync[SYNC_STAGES-1];

  assign digits = '{min_tens: min_tens, min_ones: min_ones,
                    sec_tens: sec_tens, sec_ones: sec_ones};
  assign zero   = mmss_is_zero(digits);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= done_d;
    end
  end

  // Pause (enablen high) takes priority over a tick arriving in the same cycle.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    dec_c   = 1'b0;
    load_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_c = load_evt_c && (D <= BCD_MAX);
        if (!enablen && !zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (enablen) begin
          state_d = ST_IDLE;
        end else if (tick_evt_c) begin
          dec_c = 1'b1;
          if (mmss_is_last_second(digits)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (enablen) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  countdown_timer_bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_ones (
    .clk(clk), .clrn(clrn), .dec(dec_c), .load(load_c), .load_val(D),
    .q(sec_ones), .borrow_out(so_borrow)
  );

  countdown_timer_bcd_down_digit #(.WRAP(BCD_W'(SEC_TENS_WRAP))) u_sec_tens (
    .clk(clk), .clrn(clrn), .dec(so_borrow), .load(load_c), .load_val(sec_ones),
    .q(sec_tens), .borrow_out(st_borrow)
  );

  countdown_timer_bcd_down_digit #(.WRAP(BCD_MAX)) u_min_ones (
    .clk(clk), .clrn(clrn), .dec(st_borrow), .load(load_c), .load_val(sec_tens),
    .q(min_ones), .borrow_out(mo_borrow)
  );

  // min_tens never borrows because RUN is only entered with a non-zero display.
  countdown_timer_bcd_down_digit #(.WRAP(BCD_MAX)) u_min_tens (
    .clk(clk), .clrn(clrn), .dec(mo_borrow), .load(load_c), .load_val(min_ones),
    .q(min_tens), .borrow_out(mt_borrow_unused)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: directed scenarios plus random key/tick/enable traffic vs a numeric model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       clrn;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enablen;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero;
  logic       done;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      model_n  = 0;   // display as a 4-digit decimal number MMSS
  mstate_t ms       = M_IDLE;
  int      exp_done = 0;
  int      done_cycles = 0;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk(clk), .clrn(clrn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .zero(zero), .done(done)
  );

  always @(negedge clk) if (done) done_cycles++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/digits"}, {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(model_n));
    check({tag, "/zero"}, zero, model_n == 0);
    check({tag, "/done_cycles"}, done_cycles, exp_done);
  endtask

  function automatic void settle();
    if (ms == M_IDLE && !enablen && model_n != 0) ms = M_RUN;
  endfunction

  function automatic void model_dec();
    int secs = model_n % 100;
    int mins = model_n / 100;
    if (secs > 0) model_n = model_n - 1;
    else          model_n = (mins - 1) * 100 + 59;
  endfunction

  task automatic key(input logic [3:0] d);
    @(negedge clk);
    D = d;
    loadn = 1'b0;
    repeat (8) @(negedge clk);
    loadn = 1'b1;
    repeat (4) @(negedge clk);
    if (ms == M_IDLE && d <= 4'd9) model_n = (model_n * 10 + int'(d)) % 10000;
    settle();
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic tick();
    @(negedge clk);
    pgt_1Hz = 1'b1;
    repeat (6) @(negedge clk);
    pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk);
    if (ms == M_RUN) begin
      model_dec();
      if (model_n == 0) begin
        ms = M_DONE;
        exp_done++;
      end
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge clk);
    enablen = v;
    repeat (3) @(negedge clk);
    if (v) ms = M_IDLE;
    else   settle();
  endtask

  initial begin
    clrn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; enablen = 1'b1; D = 4'd0;
    #12;
    check_all("reset");
    @(negedge clk);
    clrn = 1'b1;

    // Load latency: first digit appears on the third edge after loadn falls.
    @(negedge clk);
    D = 4'd1;
    loadn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("latency_pre", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    @(posedge clk);
    #1 check("latency_post", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);
    repeat (6) @(negedge clk);
    loadn = 1'b1;
    repeat (4) @(negedge clk);
    model_n = 1;
    key(4'd3); key(4'd0);
    check_all("load_130");
    key(4'hC);
    check_all("load_bad_digit");

    // Borrow chains
    load4(0, 1, 0, 0);
    set_en(1'b0);
    tick();
    check_all("borrow_1_00");
    set_en(1'b1);
    load4(1, 0, 0, 0);
    set_en(1'b0);
    tick();
    check_all("borrow_10_00");
    set_en(1'b1);

    // Completion
    load4(0, 0, 0, 2);
    set_en(1'b0);
    tick();
    check_all("complete_0_01");
    tick();
    check_all("complete_0_00");
    tick();
    check_all("complete_hold");
    set_en(1'b1);
    key(4'd5);
    check_all("complete_back_idle");

    // Pause and key lockout
    load4(0, 0, 1, 0);
    set_en(1'b0);
    tick();
    set_en(1'b1);
    tick(); tick();
    check_all("pause_hold");
    set_en(1'b0);
    key(4'd7);
    check_all("run_key_ignored");
    set_en(1'b1);

    // Held loadn gives exactly one shift
    @(negedge clk);
    D = 4'd2;
    loadn = 1'b0;
    repeat (100) @(negedge clk);
    loadn = 1'b1;
    repeat (4) @(negedge clk);
    model_n = (model_n * 10 + 2) % 10000;
    check_all("held_loadn");

    // Tick lands in the same cycle enablen rises: pause wins
    set_en(1'b0);
    @(negedge clk);
    pgt_1Hz = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enablen = 1'b1;
    repeat (6) @(negedge clk);
    pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk);
    ms = M_IDLE;
    check_all("tick_vs_pause");

    // Asynchronous reset mid-countdown
    set_en(1'b0);
    tick();
    check_all("pre_reset");
    @(posedge clk);
    #3 clrn = 1'b0;
    #1 check("async_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("async_reset_zero", zero, 1'b1);
    check("async_reset_done", done, 1'b0);
    model_n = 0;
    ms = M_IDLE;
    @(negedge clk);
    clrn = 1'b1;
    set_en(1'b1);
    check_all("post_reset");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      int sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        logic [3:0] d;
        d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        key(d);
      end else if (sel <= 6) begin
        tick();
      end else if (sel <= 8) begin
        set_en(1'($urandom_range(0, 1)));
      end else begin
        set_en(1'b1);
        load4(0, 0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
        set_en(1'b0);
        for (int t = 0; t < 3; t++) tick();
      end
      check_all($sformatf("rand_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
